rv32i_gcd_sequencer: RTL and testbench

Job controller that sequences the single-cycle RV32I GCD core as a request/response accelerator. Accepts one operand pair per job over a valid/ready request port and holds the core in reset between jobs. Releases the core and pulses its start input, then detects completion by watching the core's result register, with a cycle-budget timeout. Sits between the system interconnect and the CPU top's `calc_start`/`gcd_a`/`gcd_b`/`gcd_result` pins; also drives the core's reset.

---
 rtl/rv32i_gcd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_rv32i_gcd_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_gcd_sequencer.sv
// rv32i_gcd_sequencer: runs one GCD job at a time on the single-cycle RV32I
// core. The core is held in reset between jobs, released for a single start
// pulse, and declared done once its result register holds a nonzero value
// for STABLE_CYCLES consecutive RUN cycles (or timed out after MAX_CYCLES).
module rv32i_gcd_sequencer #(
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MAX_CYCLES    = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [31:0] run_cycles,
  output logic        cpu_rst_n,
  output logic        cpu_calc_start,
  output logic [31:0] cpu_gcd_a,
  output logic [31:0] cpu_gcd_b,
  input  logic [31:0] cpu_gcd_result
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CPU_RST = 3'd1,
    S_START   = 3'd2,
    S_RUN     = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] STABLE_MAX = 32'(STABLE_CYCLES);
  localparam logic [31:0] RUN_MAX    = 32'(MAX_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [31:0] stable_q, stable_d;
  logic [31:0] prev_q, prev_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        cpu_rst_n_q, cpu_rst_n_d;
  logic        cpu_start_q, cpu_start_d;
  logic [31:0] gcd_a_q, gcd_a_d;
  logic [31:0] gcd_b_q, gcd_b_d;

  // Run counter saturates so a stuck core can never wrap the reported count.
  logic [31:0] run_inc_s;
  logic [31:0] stable_nxt_s;
  assign run_inc_s    = (run_cnt_q == 32'hFFFF_FFFF) ? run_cnt_q : run_cnt_q + 32'd1;
  // A zero result breaks the streak; a new nonzero value restarts it at 1.
  assign stable_nxt_s = (cpu_gcd_result == 32'd0) ? 32'd0 :
                        (cpu_gcd_result == prev_q) ? stable_q + 32'd1 : 32'd1;

  // Next-state and next-output decode for the job sequencer.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    run_cnt_d     = run_cnt_q;
    stable_d      = stable_q;
    prev_d        = 32'd0;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    run_cycles_d  = run_cycles_q;
    gcd_a_d       = gcd_a_q;
    gcd_b_d       = gcd_b_q;
    case (state_q)
      S_IDLE: begin
        rst_cnt_d = 32'd0;
        run_cnt_d = 32'd0;
        stable_d  = 32'd0;
        if (req_valid) begin
          gcd_a_d = req_a;
          gcd_b_d = req_b;
          if ((req_a == 32'd0) || (req_b == 32'd0)) begin
            // gcd(x,0)=x and gcd(0,0)=0, so the core is never released.
            rsp_result_d  = req_a | req_b;
            rsp_timeout_d = 1'b0;
            run_cycles_d  = 32'd0;
            state_d       = S_RESP;
          end else begin
            state_d = S_CPU_RST;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CPU_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      S_START: begin
        run_cnt_d = 32'd0;
        stable_d  = 32'd0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        prev_d    = cpu_gcd_result;
        run_cnt_d = run_inc_s;
        stable_d  = stable_nxt_s;
        // Completion is tested first so it wins over a same-cycle timeout.
        if (stable_nxt_s == STABLE_MAX) begin
          rsp_result_d  = cpu_gcd_result;
          rsp_timeout_d = 1'b0;
          run_cycles_d  = run_inc_s;
          state_d       = S_RESP;
        end else if (run_inc_s == RUN_MAX) begin
          rsp_result_d  = 32'd0;
          rsp_timeout_d = 1'b1;
          run_cycles_d  = run_inc_s;
          state_d       = S_RESP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Registered outputs are decoded from the state being entered.
    rsp_valid_d = (state_d == S_RESP);
    cpu_rst_n_d = (state_d == S_START) || (state_d == S_RUN);
    cpu_start_d = (state_d == S_START);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= 32'd0;
      run_cnt_q     <= 32'd0;
      stable_q      <= 32'd0;
      prev_q        <= 32'd0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_timeout_q <= 1'b0;
      run_cycles_q  <= 32'd0;
      cpu_rst_n_q   <= 1'b0;
      cpu_start_q   <= 1'b0;
      gcd_a_q       <= 32'd0;
      gcd_b_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      run_cnt_q     <= run_cnt_d;
      stable_q      <= stable_d;
      prev_q        <= prev_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      run_cycles_q  <= run_cycles_d;
      cpu_rst_n_q   <= cpu_rst_n_d;
      cpu_start_q   <= cpu_start_d;
      gcd_a_q       <= gcd_a_d;
      gcd_b_q       <= gcd_b_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign run_cycles     = run_cycles_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign cpu_calc_start = cpu_start_q;
  assign cpu_gcd_a      = gcd_a_q;
  assign cpu_gcd_b      = gcd_b_q;

endmodule

// File: tb/tb_rv32i_gcd_sequencer.sv
// Directed bench for rv32i_gcd_sequencer with a behavioural core model whose
// result register follows a per-scenario schedule of RUN cycle numbers.
module tb_rv32i_gcd_sequencer;

  localparam int TB_MAX = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] run_cycles;
  logic        cpu_rst_n;
  logic        cpu_calc_start;
  logic [31:0] cpu_gcd_a;
  logic [31:0] cpu_gcd_b;
  logic [31:0] cpu_gcd_result;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Core model: mode 0 writes model_val at RUN cycle 20, mode 1 glitches, mode 2 never writes.
  int          mode;
  logic [31:0] model_val;
  int          cyc;

  rv32i_gcd_sequencer #(.RST_CYCLES(2), .STABLE_CYCLES(4), .MAX_CYCLES(TB_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy),
    .run_cycles(run_cycles), .cpu_rst_n(cpu_rst_n), .cpu_calc_start(cpu_calc_start),
    .cpu_gcd_a(cpu_gcd_a), .cpu_gcd_b(cpu_gcd_b), .cpu_gcd_result(cpu_gcd_result)
  );

  always #5 clk = ~clk;

  // Core RUN-cycle counter: cyc equals k during RUN cycle k.
  always @(posedge clk) begin
    if (!cpu_rst_n) cyc <= 0;
    else if (cpu_calc_start) cyc <= 1;
    else cyc <= cyc + 1;
  end

  always_comb begin
    cpu_gcd_result = 32'd0;
    if (mode == 0) begin
      if (cyc >= 20) cpu_gcd_result = model_val;
    end else if (mode == 1) begin
      if (cyc == 10 || cyc == 11) cpu_gcd_result = 32'd5;
      else if (cyc >= 13) cpu_gcd_result = 32'd7;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one job and runs until rsp_valid; n counts cycles since the accept edge.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                         output int n, output int starts, output int lows, output bit ok);
    n = 0; starts = 0; lows = 0; ok = 1'b0;
    req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      req_valid = 1'b0;
      n++;
      if (cpu_calc_start) starts++;
      if (!cpu_rst_n && starts == 0) lows++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec_cnt++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL handshake_idle: req_ready=%0b rsp_valid=%0b expected 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    mode = 2; model_val = 32'd0;
    tick(); tick();
    vec_cnt++; if ({rsp_valid, rsp_timeout, cpu_rst_n, cpu_calc_start} !== 4'b0000) begin err_cnt++; $display("FAIL reset_flags: got %b expected 0000", {rsp_valid, rsp_timeout, cpu_rst_n, cpu_calc_start}); end
    vec_cnt++; if (rsp_result !== 32'd0 || run_cycles !== 32'd0) begin err_cnt++; $display("FAIL reset_values: result=%0d run_cycles=%0d expected 0/0", rsp_result, run_cycles); end
    vec_cnt++; if (cpu_gcd_a !== 32'd0 || cpu_gcd_b !== 32'd0) begin err_cnt++; $display("FAIL reset_operands: a=%0d b=%0d expected 0/0", cpu_gcd_a, cpu_gcd_b); end
    rst_n = 1'b1;
    tick();
    vec_cnt++; if (req_ready !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL reset_idle: req_ready=%0b busy=%0b expected 1/0", req_ready, busy); end
  endtask

  task automatic test_nominal();
    int n, starts, lows; bit ok;
    mode = 0; model_val = 32'd6;
    run_job(32'd48, 32'd18, n, starts, lows, ok);
    vec_cnt++; if (!ok || n != 27) begin err_cnt++; $display("FAIL nominal_latency: ok=%0b cycles=%0d expected 27", ok, n); end
    vec_cnt++; if (rsp_result !== 32'd6 || rsp_timeout !== 1'b0) begin err_cnt++; $display("FAIL nominal_result: result=%0d timeout=%0b expected 6/0", rsp_result, rsp_timeout); end
    vec_cnt++; if (run_cycles !== 32'd23) begin err_cnt++; $display("FAIL nominal_run_cycles: got %0d expected 23", run_cycles); end
    vec_cnt++; if (starts != 1 || lows != 2) begin err_cnt++; $display("FAIL nominal_pulses: starts=%0d rst_low=%0d expected 1/2", starts, lows); end
    vec_cnt++; if (cpu_gcd_a !== 32'd48 || cpu_gcd_b !== 32'd18 || cpu_rst_n !== 1'b0) begin err_cnt++; $display("FAIL nominal_cpu_pins: a=%0d b=%0d rst_n=%0b expected 48/18/0", cpu_gcd_a, cpu_gcd_b, cpu_rst_n); end
    handshake();
  endtask

  task automatic test_glitch();
    int n, starts, lows; bit ok;
    mode = 1;
    run_job(32'd49, 32'd21, n, starts, lows, ok);
    vec_cnt++; if (!ok || n != 20) begin err_cnt++; $display("FAIL glitch_latency: ok=%0b cycles=%0d expected 20", ok, n); end
    vec_cnt++; if (rsp_result !== 32'd7 || run_cycles !== 32'd16) begin err_cnt++; $display("FAIL glitch_result: result=%0d run_cycles=%0d expected 7/16", rsp_result, run_cycles); end
    handshake();
  endtask

  task automatic test_timeout();
    int n, starts, lows; bit ok;
    mode = 2;
    run_job(32'd9, 32'd6, n, starts, lows, ok);
    vec_cnt++; if (!ok || n != TB_MAX + 4) begin err_cnt++; $display("FAIL timeout_latency: ok=%0b cycles=%0d expected %0d", ok, n, TB_MAX + 4); end
    vec_cnt++; if (rsp_timeout !== 1'b1 || rsp_result !== 32'd0) begin err_cnt++; $display("FAIL timeout_flags: timeout=%0b result=%0d expected 1/0", rsp_timeout, rsp_result); end
    vec_cnt++; if (run_cycles !== 32'(TB_MAX) || cpu_rst_n !== 1'b0) begin err_cnt++; $display("FAIL timeout_run_cycles: run_cycles=%0d cpu_rst_n=%0b expected %0d/0", run_cycles, cpu_rst_n, TB_MAX); end
    handshake();
  endtask

  task automatic test_shortcut();
    int n, starts, lows; bit ok;
    logic [31:0] va [2];
    logic [31:0] vb [2];
    va[0] = 32'd0; vb[0] = 32'd35;
    va[1] = 32'd0; vb[1] = 32'd0;
    mode = 0; model_val = 32'd99;
    for (int j = 0; j < 2; j++) begin
      run_job(va[j], vb[j], n, starts, lows, ok);
      vec_cnt++; if (!ok || n != 1) begin err_cnt++; $display("FAIL shortcut_latency%0d: ok=%0b cycles=%0d expected 1", j, ok, n); end
      vec_cnt++; if (rsp_result !== (va[j] | vb[j]) || rsp_timeout !== 1'b0 || run_cycles !== 32'd0) begin err_cnt++; $display("FAIL shortcut_result%0d: result=%0d timeout=%0b run_cycles=%0d expected %0d/0/0", j, rsp_result, rsp_timeout, run_cycles, va[j] | vb[j]); end
      for (int i = 0; i < 3; i++) begin
        tick();
        if (cpu_calc_start) starts++;
        if (cpu_rst_n) lows = -100;
      end
      vec_cnt++; if (starts != 0 || lows < 0) begin err_cnt++; $display("FAIL shortcut_core_idle%0d: starts=%0d rst_released=%0b expected 0/0", j, starts, lows < 0); end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int n, starts, lows; bit ok; int bad;
    mode = 0; model_val = 32'd6;
    run_job(32'd48, 32'd18, n, starts, lows, ok);
    vec_cnt++; if (!ok || rsp_result !== 32'd6) begin err_cnt++; $display("FAIL b2b_first: ok=%0b result=%0d expected 6", ok, rsp_result); end
    req_a = 32'd100; req_b = 32'd75; req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd6 || rsp_timeout !== 1'b0 || run_cycles !== 32'd23) bad++;
      if (req_ready !== 1'b0 || cpu_gcd_a !== 32'd48 || cpu_rst_n !== 1'b0) bad++;
    end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL b2b_backpressure: %0d unstable cycles expected 0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vec_cnt++; if (req_ready !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_gap: req_ready=%0b busy=%0b expected 1/0", req_ready, busy); end
    model_val = 32'd25;
    run_job(32'd100, 32'd75, n, starts, lows, ok);
    vec_cnt++; if (!ok || n != 27 || rsp_result !== 32'd25 || cpu_gcd_a !== 32'd100) begin err_cnt++; $display("FAIL b2b_second: ok=%0b cycles=%0d result=%0d a=%0d expected 27/25/100", ok, n, rsp_result, cpu_gcd_a); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int n, starts, lows; bit ok; bit found;
    mode = 0; model_val = 32'd6;
    req_a = 32'd30; req_b = 32'd12; req_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      req_valid = 1'b0;
      if (cpu_calc_start) begin
        found = 1'b1;
        break;
      end
    end
    vec_cnt++; if (!found) begin err_cnt++; $display("FAIL midrun_start: start pulse seen=%0b expected 1", found); end
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vec_cnt++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL midrun_idle: busy=%0b req_ready=%0b rsp_valid=%0b expected 0/1/0", busy, req_ready, rsp_valid); end
    vec_cnt++; if (cpu_rst_n !== 1'b0 || run_cycles !== 32'd0) begin err_cnt++; $display("FAIL midrun_outputs: cpu_rst_n=%0b run_cycles=%0d expected 0/0", cpu_rst_n, run_cycles); end
    model_val = 32'd4;
    run_job(32'd12, 32'd8, n, starts, lows, ok);
    vec_cnt++; if (!ok || n != 27 || rsp_result !== 32'd4 || run_cycles !== 32'd23) begin err_cnt++; $display("FAIL midrun_recover: ok=%0b cycles=%0d result=%0d run_cycles=%0d expected 27/4/23", ok, n, rsp_result, run_cycles); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_shortcut();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
